uart_pi_master: RTL and testbench

- Bus initiator for the uP register interface; it is the master that drives the blk_sel/addr/wr_en/rd_en strobes the UART register block responds to.
- Polls the UART block status, pulls command bytes from its RX FIFO, and executes single-byte register reads/writes on the target blocks.
- Returns one response byte per command through the UART TX FIFO, giving a host PC register access over the serial link.

---
 rtl/uart_pi_master.sv | 218 +++++++++++++++++++++
 tb/tb_uart_pi_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pi_master.sv
// Bus master that serves host register commands from the UART RX FIFO and answers through the UART TX FIFO.
// Each command is one byte: bit7 = write, bits6:4 = target block, bits3:0 = register address.
module uart_pi_master #(
    parameter int unsigned NUM_BLK      = 8,
    parameter int unsigned UART_BLK     = 0,
    parameter logic [3:0]  ADDR_STATUS  = 4'h0,
    parameter logic [3:0]  ADDR_RD_FIFO = 4'h1,
    parameter logic [3:0]  ADDR_WR_FIFO = 4'h2,
    parameter int unsigned TIMEOUT      = 50000,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [NUM_BLK-1:0] pi_blk_sel,
    output logic [3:0]         pi_addr,
    output logic               pi_wr_en,
    output logic               pi_rd_en,
    output logic [7:0]         pi_wr_data,
    input  logic [7:0]         pi_rd_data,
    output logic               busy,
    output logic               cmd_err,
    output logic [7:0]         err_cnt
);

    localparam int unsigned        TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [NUM_BLK-1:0] UART_SEL = NUM_BLK'(1) << UART_BLK;

    typedef enum logic [2:0] {
        S_POLL_RX,
        S_RD_CMD,
        S_POLL_DATA,
        S_RD_DATA,
        S_TGT_WR,
        S_TGT_RD,
        S_POLL_TX,
        S_WR_TX
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_en;
    logic [7:0]         r_cmd;
    logic [7:0]         r_data;
    logic [7:0]         r_resp;
    logic [TMR_W-1:0]   r_timer;
    logic               r_busy;
    logic               r_cmd_err;
    logic [7:0]         r_err_cnt;

    logic [7:0]         w_cmd_nxt;
    logic [7:0]         w_data_nxt;
    logic [7:0]         w_resp_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               w_err;
    logic               w_rx_rdy;
    logic               w_tx_rdy;
    logic [NUM_BLK-1:0] w_new_sel;
    logic               w_new_illegal;
    logic [NUM_BLK-1:0] w_tgt_sel;

    assign w_rx_rdy  = pi_rd_data[0];
    assign w_tx_rdy  = pi_rd_data[2];
    // An id outside NUM_BLK shifts the one-hot out of range and yields zero.
    assign w_new_sel     = NUM_BLK'(1) << pi_rd_data[6:4];
    assign w_new_illegal = (w_new_sel == '0) || w_new_sel[UART_BLK];
    assign w_tgt_sel     = NUM_BLK'(1) << r_cmd[6:4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_POLL_RX;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-next logic
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_data_nxt  = r_data;
        w_resp_nxt  = r_resp;
        w_timer_nxt = r_timer;
        w_err       = 1'b0;
        case (r_state)
            S_POLL_RX: begin
                if (r_en && w_rx_rdy) begin
                    w_state_nxt = S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                w_cmd_nxt = pi_rd_data;
                if (w_new_illegal) begin
                    w_resp_nxt  = NAK_BYTE;
                    w_err       = 1'b1;
                    w_state_nxt = S_POLL_TX;
                end else if (pi_rd_data[7]) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_POLL_DATA;
                end else begin
                    w_state_nxt = S_TGT_RD;
                end
            end
            S_POLL_DATA: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (w_rx_rdy) begin
                    w_state_nxt = S_RD_DATA;
                end else if ((TIMEOUT != 0) && (r_timer == TMR_LAST)) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_POLL_RX;
                end
            end
            S_RD_DATA: begin
                w_data_nxt  = pi_rd_data;
                w_state_nxt = S_TGT_WR;
            end
            S_TGT_WR: begin
                w_resp_nxt  = ACK_BYTE;
                w_state_nxt = S_POLL_TX;
            end
            S_TGT_RD: begin
                w_resp_nxt  = pi_rd_data;
                w_state_nxt = S_POLL_TX;
            end
            S_POLL_TX: begin
                if (w_tx_rdy) begin
                    w_state_nxt = S_WR_TX;
                end
            end
            S_WR_TX: begin
                w_state_nxt = S_POLL_RX;
            end
            default: begin
                w_state_nxt = S_POLL_RX;
            end
        endcase
    end

    // Latched command registers, error pulse and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en      <= 1'b0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_resp    <= '0;
            r_timer   <= '0;
            r_busy    <= 1'b0;
            r_cmd_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_en      <= en;
            r_cmd     <= w_cmd_nxt;
            r_data    <= w_data_nxt;
            r_resp    <= w_resp_nxt;
            r_timer   <= w_timer_nxt;
            r_busy    <= (w_state_nxt != S_POLL_RX);
            r_cmd_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Moore bus decode; en is registered so reset forces an idle bus
    always_comb begin
        pi_blk_sel = '0;
        pi_addr    = '0;
        pi_wr_en   = 1'b0;
        pi_rd_en   = 1'b0;
        pi_wr_data = '0;
        case (r_state)
            S_POLL_RX: begin
                if (r_en) begin
                    pi_blk_sel = UART_SEL;
                    pi_addr    = ADDR_STATUS;
                    pi_rd_en   = 1'b1;
                end
            end
            S_POLL_DATA, S_POLL_TX: begin
                pi_blk_sel = UART_SEL;
                pi_addr    = ADDR_STATUS;
                pi_rd_en   = 1'b1;
            end
            S_RD_CMD, S_RD_DATA: begin
                pi_blk_sel = UART_SEL;
                pi_addr    = ADDR_RD_FIFO;
                pi_rd_en   = 1'b1;
            end
            S_TGT_WR: begin
                pi_blk_sel = w_tgt_sel;
                pi_addr    = r_cmd[3:0];
                pi_wr_en   = 1'b1;
                pi_wr_data = r_data;
            end
            S_TGT_RD: begin
                pi_blk_sel = w_tgt_sel;
                pi_addr    = r_cmd[3:0];
                pi_rd_en   = 1'b1;
            end
            S_WR_TX: begin
                pi_blk_sel = UART_SEL;
                pi_addr    = ADDR_WR_FIFO;
                pi_wr_en   = 1'b1;
                pi_wr_data = r_resp;
            end
            default: begin
            end
        endcase
    end

    assign busy    = r_busy;
    assign cmd_err = r_cmd_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_uart_pi_master.sv
// Bench for uart_pi_master: a UART/target responder model plus an event-level reference of the command protocol.
module tb_uart_pi_master;

    localparam int unsigned NB  = 8;
    localparam int unsigned TMO = 10;
    localparam logic [7:0] EV_RD = 8'd1, EV_WR = 8'd2, EV_TX = 8'd3, EV_ERR = 8'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  pi_blk_sel;
    logic [3:0]  pi_addr;
    logic        pi_wr_en;
    logic        pi_rd_en;
    logic [7:0]  pi_wr_data;
    logic [7:0]  pi_rd_data;
    logic        busy;
    logic        cmd_err;
    logic [7:0]  err_cnt;

    // Responder state: RX FIFO, TX ready flag and target register files
    logic [7:0]  rx_mem [0:4095];
    int          rx_wr = 0;
    int          rx_rd = 0;
    logic        tx_rdy;
    logic [7:0]  tgt_mem [0:127];
    logic [7:0]  ref_mem [0:127];
    logic        p_pop = 1'b0;

    logic [31:0] ev_q[$];
    logic [31:0] exp_q[$];
    int          tx_cyc[$];
    int          fifo_cyc[$];
    int          cyc = 0;
    int          n_busy = 0, n_acc = 0, n_stat_since = 0, stat_at_err = -1, n_errp = 0, viol = 0;
    int          n_chk = 0, n_fail = 0;
    int          illegal_n, t_set, k;

    uart_pi_master #(.NUM_BLK(NB), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pi_blk_sel (pi_blk_sel),
        .pi_addr    (pi_addr),
        .pi_wr_en   (pi_wr_en),
        .pi_rd_en   (pi_rd_en),
        .pi_wr_data (pi_wr_data),
        .pi_rd_data (pi_rd_data),
        .busy       (busy),
        .cmd_err    (cmd_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] sel2idx(input logic [7:0] s);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (s[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [31:0] ev(input logic [7:0] kd, input logic [7:0] s,
                                       input logic [3:0] a, input logic [7:0] d);
        return {kd, s, 4'h0, a, d};
    endfunction

    // Combinational read data from the UART block and the targets
    always_comb begin
        pi_rd_data = 8'h00;
        if (pi_rd_en) begin
            if (pi_blk_sel == 8'h01) begin
                if (pi_addr == 4'h0)      pi_rd_data = {5'b0, tx_rdy, 1'b0, (rx_wr != rx_rd)};
                else if (pi_addr == 4'h1) pi_rd_data = rx_mem[12'(rx_rd)];
            end else begin
                pi_rd_data = tgt_mem[{sel2idx(pi_blk_sel), pi_addr}];
            end
        end
    end

    // Bus monitor on the falling edge; FIFO pops are applied at the next rising edge
    always @(negedge clk) begin
        cyc   = cyc + 1;
        p_pop = 1'b0;
        if (rst_n) begin
            if (busy) n_busy++;
            if (pi_wr_en && pi_rd_en) viol++;
            if (!pi_wr_en && pi_wr_data != 8'h00) viol++;
            if ((pi_wr_en || pi_rd_en) != (pi_blk_sel != 8'h00)) viol++;
            if (pi_blk_sel != 8'h00 && !$onehot(pi_blk_sel)) viol++;
            if (pi_wr_en || pi_rd_en) n_acc++;
            if (cmd_err) begin
                ev_q.push_back(ev(EV_ERR, 8'h00, 4'h0, 8'h00));
                stat_at_err = n_stat_since;
                n_errp++;
            end
            if (pi_blk_sel == 8'h01) begin
                if (pi_rd_en && pi_addr == 4'h0) begin
                    n_stat_since++;
                end else if (pi_rd_en && pi_addr == 4'h1) begin
                    p_pop = 1'b1;
                    fifo_cyc.push_back(cyc);
                    n_stat_since = 0;
                end else if (pi_wr_en && pi_addr == 4'h2) begin
                    ev_q.push_back(ev(EV_TX, 8'h00, 4'h0, pi_wr_data));
                    tx_cyc.push_back(cyc);
                end else if (pi_rd_en || pi_wr_en) begin
                    viol++;
                end
            end else if (pi_rd_en) begin
                ev_q.push_back(ev(EV_RD, pi_blk_sel, pi_addr, pi_rd_data));
            end else if (pi_wr_en) begin
                ev_q.push_back(ev(EV_WR, pi_blk_sel, pi_addr, pi_wr_data));
                tgt_mem[{sel2idx(pi_blk_sel), pi_addr}] = pi_wr_data;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && p_pop) rx_rd <= rx_rd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic rstep();
        step();
        tx_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[12'(rx_wr)] = b;
        rx_wr++;
    endtask

    task automatic clear_obs();
        ev_q.delete();
        exp_q.delete();
        tx_cyc.delete();
        fifo_cyc.delete();
        n_busy = 0;
        n_acc = 0;
        n_errp = 0;
        stat_at_err = -1;
    endtask

    task automatic wait_tx(input int n, input int bound, input string tag);
        int w = 0;
        while (tx_cyc.size() < n && w < bound) begin
            step();
            w++;
        end
        check(tag, tx_cyc.size(), n);
    endtask

    task automatic cmp_events(input string tag);
        check({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
    endtask

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        tx_rdy = 1'b1;
        for (int i = 0; i < 128; i++) tgt_mem[i] = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        check("rst_sel", pi_blk_sel, 8'h00);
        check("rst_bus", {pi_addr, pi_wr_en, pi_rd_en, pi_wr_data}, 32'h0);
        check("rst_status", {busy, cmd_err, err_cnt}, 32'h0);
        step(3);
        rst_n = 1'b1;
        en    = 1'b1;
        step(3);

        // Read command to block 2 register 3
        tgt_mem[{3'd2, 4'd3}] = 8'hA7;
        clear_obs();
        push(8'h23);
        wait_tx(1, 40, "rd_wait");
        step(2);
        exp_q.push_back(ev(EV_RD, 8'h04, 4'h3, 8'hA7));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'hA7));
        cmp_events("rd");
        check("rd_busy_cycles", n_busy, 4);
        check("rd_latency", tx_cyc[0] - fifo_cyc[0], 3);

        // Write command to block 3 register 5
        clear_obs();
        push(8'hB5);
        push(8'h3C);
        wait_tx(1, 40, "wr_wait");
        step(2);
        exp_q.push_back(ev(EV_WR, 8'h08, 4'h5, 8'h3C));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h06));
        cmp_events("wr");
        check("wr_busy_cycles", n_busy, 6);
        check("wr_latency", tx_cyc[0] - fifo_cyc[0], 5);

        // Illegal target, then the following byte is a fresh command
        clear_obs();
        push(8'h01);
        push(8'h23);
        wait_tx(2, 60, "nak_wait");
        step(2);
        exp_q.push_back(ev(EV_ERR, 8'h00, 4'h0, 8'h00));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h15));
        exp_q.push_back(ev(EV_RD, 8'h04, 4'h3, 8'hA7));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'hA7));
        cmp_events("nak");
        check("nak_err_cnt", err_cnt, 8'd1);
        check("nak_pulses", n_errp, 1);

        // Write command whose data byte never arrives
        clear_obs();
        push(8'h91);
        k = 0;
        while (n_errp < 1 && k < 60) begin step(); k++; end
        step(5);
        exp_q.push_back(ev(EV_ERR, 8'h00, 4'h0, 8'h00));
        cmp_events("tmo");
        check("tmo_polls", stat_at_err, TMO);
        check("tmo_no_tx", tx_cyc.size(), 0);
        check("tmo_err_cnt", err_cnt, 8'd2);
        check("tmo_idle", busy, 1'b0);

        // TX backpressure during a read response
        clear_obs();
        tgt_mem[{3'd2, 4'd3}] = 8'h5A;
        tx_rdy = 1'b0;
        push(8'h23);
        k = 0;
        while (ev_q.size() < 1 && k < 40) begin step(); k++; end
        check("bp_rd_seen", ev_q.size(), 1);
        step(20);
        check("bp_polls", n_stat_since, 20);
        check("bp_no_tx", tx_cyc.size(), 0);
        tx_rdy = 1'b1;
        t_set  = cyc;
        wait_tx(1, 10, "bp_wait");
        check("bp_tx_cycle", tx_cyc[0] - t_set, 1);
        step(2);
        exp_q.push_back(ev(EV_RD, 8'h04, 4'h3, 8'h5A));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h5A));
        cmp_events("bp");

        // Reset during the target write, then hold en low
        clear_obs();
        push(8'hB5);
        push(8'h77);
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            if (pi_wr_en && pi_blk_sel == 8'h08) break;
            k++;
        end
        check("rstw_reached", {pi_wr_en, pi_blk_sel}, {1'b1, 8'h08});
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("rstw_bus", {pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data}, 32'h0);
        check("rstw_status", {busy, cmd_err, err_cnt}, 32'h0);
        step(2);
        rst_n = 1'b1;
        clear_obs();
        push(8'h23);
        step(100);
        check("en_off_acc", n_acc, 0);
        check("en_off_busy", n_busy, 0);
        check("en_off_rx_kept", rx_wr - rx_rd, 1);
        check("rstw_no_write", tgt_mem[{3'd3, 4'd5}], 8'h3C);
        en = 1'b1;
        wait_tx(1, 40, "en_on_wait");
        step(2);
        exp_q.push_back(ev(EV_RD, 8'h04, 4'h3, 8'h5A));
        exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h5A));
        cmp_events("en_on");

        // Randomized command stream against the reference model
        for (int i = 0; i < 128; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            tgt_mem[i] = v;
            ref_mem[i] = v;
        end
        clear_obs();
        illegal_n = 0;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] c, d;
            int id;
            c  = 8'($urandom);
            id = int'(c[6:4]);
            push(c);
            if (id == 0 || id >= int'(NB)) begin
                exp_q.push_back(ev(EV_ERR, 8'h00, 4'h0, 8'h00));
                exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h15));
                illegal_n++;
            end else if (c[7]) begin
                d = 8'($urandom);
                repeat ($urandom_range(0, 6)) rstep();
                push(d);
                ref_mem[{c[6:4], c[3:0]}] = d;
                exp_q.push_back(ev(EV_WR, 8'(1 << id), c[3:0], d));
                exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, 8'h06));
            end else begin
                exp_q.push_back(ev(EV_RD, 8'(1 << id), c[3:0], ref_mem[{c[6:4], c[3:0]}]));
                exp_q.push_back(ev(EV_TX, 8'h00, 4'h0, ref_mem[{c[6:4], c[3:0]}]));
            end
            repeat ($urandom_range(0, 8)) rstep();
        end
        k = 0;
        while (!(ev_q.size() >= exp_q.size() && rx_rd == rx_wr && !busy) && k < 3000) begin
            rstep();
            k++;
        end
        tx_rdy = 1'b1;
        step(3);
        cmp_events("rnd");
        check("rnd_err_cnt", err_cnt, 32'(illegal_n));

        // Error counter saturation
        clear_obs();
        for (int i = 0; i < 300; i++) push(8'h0A);
        k = 0;
        while (n_errp < 300 && k < 4000) begin step(); k++; end
        step(6);
        check("sat_pulses", n_errp, 300);
        check("sat_err_cnt", err_cnt, 8'hFF);
        check("sat_tx_count", tx_cyc.size(), 300);
        check("protocol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
        $finish;
    end

endmodule
